// File: rtl/floppy_voice_bank_if.sv
// Command channel from the MIDI decoder into the floppy voice bank.
// The master drives note commands and the slave answers with cmd_ready.
interface floppy_voice_bank_if #(
    parameter int CHAN_W = 2
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_on;
    logic [CHAN_W-1:0] cmd_chan;
    logic [6:0]        cmd_note;

    modport master (
        output cmd_valid,
        output cmd_on,
        output cmd_chan,
        output cmd_note,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_on,
        input  cmd_chan,
        input  cmd_note,
        output cmd_ready
    );
endinterface

// File: rtl/floppy_voice_bank.sv
// Multi-channel floppy tone generator: homes every head, then plays one note per
// drive by toggling STEP at a per-note half period and bouncing between track limits.
module floppy_voice_bank #(
    parameter int CHANNELS  = 4,
    parameter int CHAN_W    = 2,
    parameter int TRACKS    = 80,
    parameter int HOME_HALF = 75000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    floppy_voice_bank_if.slave    cmd,
    output logic [CHANNELS-1:0]   step_n,
    output logic [CHANNELS-1:0]   dir,
    output logic [CHANNELS-1:0]   playing
);
    localparam int TRK_W = $clog2(TRACKS + 1);
    localparam int HC_W  = $clog2(HOME_HALF + 1);
    localparam int HF_W  = $clog2(TRACKS + 1);

    typedef enum logic {
        ST_HOME = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Half-period of MIDI notes 0..11 at 25 MHz-equivalent count (50 MHz clock, half period).
    function automatic logic [21:0] semi_lut(input logic [6:0] k);
        logic [21:0] v;
        case (k)
            7'd0:    v = 22'd3057805;
            7'd1:    v = 22'd2886184;
            7'd2:    v = 22'd2724195;
            7'd3:    v = 22'd2571297;
            7'd4:    v = 22'd2426982;
            7'd5:    v = 22'd2290766;
            7'd6:    v = 22'd2162195;
            7'd7:    v = 22'd2040840;
            7'd8:    v = 22'd1926297;
            7'd9:    v = 22'd1818182;
            7'd10:   v = 22'd1716135;
            7'd11:   v = 22'd1619816;
            default: v = 22'd0;
        endcase
        return v;
    endfunction

    // Direction chosen on a STEP rising edge: reverse at either end of travel.
    function automatic logic dir_at_rise(input logic [TRK_W-1:0] trk, input logic dir_cur);
        logic r;
        if (trk == TRK_W'(TRACKS - 1)) begin
            r = 1'b1;
        end else if (trk == '0) begin
            r = 1'b0;
        end else begin
            r = dir_cur;
        end
        return r;
    endfunction

    state_t                state_q, state_d;
    logic [HC_W-1:0]       home_cnt_q, home_cnt_d;
    logic [HF_W-1:0]       home_falls_q, home_falls_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic [CHANNELS-1:0]   step_n_q, step_n_d;
    logic [CHANNELS-1:0]   dir_q, dir_d;
    logic [CHANNELS-1:0]   playing_q, playing_d;
    logic [6:0]            note_q  [CHANNELS];
    logic [6:0]            note_d  [CHANNELS];
    logic [22:0]           setp_q  [CHANNELS];
    logic [22:0]           setp_d  [CHANNELS];
    logic [22:0]           cnt_q   [CHANNELS];
    logic [22:0]           cnt_d   [CHANNELS];
    logic [TRK_W-1:0]      track_q [CHANNELS];
    logic [TRK_W-1:0]      track_d [CHANNELS];

    logic                  cmd_fire_s;
    logic                  note_ok_s;
    logic                  chan_ok_s;
    logic [6:0]            oct_s;
    logic [6:0]            semi_s;
    logic [22:0]           setp_s;

    // Decode the incoming command into octave, semitone and setpoint.
    always_comb begin
        cmd_fire_s = cmd.cmd_valid && cmd_ready_q;
        note_ok_s  = (cmd.cmd_note >= 7'd24) && (cmd.cmd_note <= 7'd83);
        chan_ok_s  = ({1'b0, cmd.cmd_chan} < (CHAN_W + 1)'(CHANNELS));
        oct_s      = cmd.cmd_note / 7'd12;
        semi_s     = cmd.cmd_note - (oct_s * 7'd12);
        setp_s     = {1'b0, semi_lut(semi_s)} >> oct_s;
    end

    // Next-state logic for homing sequencer and all voice channels.
    always_comb begin
        state_d      = state_q;
        home_cnt_d   = home_cnt_q;
        home_falls_d = home_falls_q;
        cmd_ready_d  = cmd_ready_q;
        step_n_d     = step_n_q;
        dir_d        = dir_q;
        playing_d    = playing_q;
        note_d       = note_q;
        setp_d       = setp_q;
        cnt_d        = cnt_q;
        track_d      = track_q;

        case (state_q)
            ST_HOME: begin
                cmd_ready_d = 1'b0;
                if (home_cnt_q == HC_W'(HOME_HALF - 1)) begin
                    home_cnt_d = '0;
                    if (step_n_q[0]) begin
                        step_n_d     = '0;
                        home_falls_d = home_falls_q + 1'b1;
                    end else begin
                        step_n_d = '1;
                        // The rising edge after the last falling edge ends homing.
                        if (home_falls_q == HF_W'(TRACKS)) begin
                            state_d      = ST_RUN;
                            cmd_ready_d  = 1'b1;
                            dir_d        = '0;
                            home_falls_d = '0;
                            for (int c = 0; c < CHANNELS; c++) begin
                                track_d[c] = '0;
                            end
                        end else begin
                            state_d = ST_HOME;
                        end
                    end
                end else begin
                    home_cnt_d = home_cnt_q + 1'b1;
                end
            end

            ST_RUN: begin
                cmd_ready_d = 1'b1;
                for (int c = 0; c < CHANNELS; c++) begin
                    if (playing_q[c]) begin
                        if (cnt_q[c] == setp_q[c] - 23'd1) begin
                            cnt_d[c]    = '0;
                            step_n_d[c] = ~step_n_q[c];
                            if (step_n_q[c]) begin
                                if (dir_q[c]) begin
                                    track_d[c] = track_q[c] - 1'b1;
                                end else begin
                                    track_d[c] = track_q[c] + 1'b1;
                                end
                            end else begin
                                dir_d[c] = dir_at_rise(track_q[c], dir_q[c]);
                            end
                        end else begin
                            cnt_d[c] = cnt_q[c] + 23'd1;
                        end
                    end else begin
                        cnt_d[c] = cnt_q[c];
                    end

                    // A command for this channel overrides its free-running update.
                    if (cmd_fire_s && chan_ok_s && (cmd.cmd_chan == CHAN_W'(c))) begin
                        if (cmd.cmd_on) begin
                            if (note_ok_s) begin
                                note_d[c]    = cmd.cmd_note;
                                setp_d[c]    = setp_s;
                                cnt_d[c]     = '0;
                                playing_d[c] = 1'b1;
                                step_n_d[c]  = step_n_q[c];
                                track_d[c]   = track_q[c];
                                dir_d[c]     = dir_q[c];
                            end else begin
                                playing_d[c] = playing_d[c];
                            end
                        end else if (playing_q[c] && (cmd.cmd_note == note_q[c])) begin
                            playing_d[c] = 1'b0;
                            step_n_d[c]  = 1'b1;
                            cnt_d[c]     = '0;
                            track_d[c]   = track_q[c];
                            if (!step_n_q[c]) begin
                                dir_d[c] = dir_at_rise(track_q[c], dir_q[c]);
                            end else begin
                                dir_d[c] = dir_q[c];
                            end
                        end else begin
                            playing_d[c] = playing_d[c];
                        end
                    end else begin
                        playing_d[c] = playing_d[c];
                    end
                end
            end

            default: begin
                state_d     = ST_HOME;
                cmd_ready_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_HOME;
            home_cnt_q   <= '0;
            home_falls_q <= '0;
            cmd_ready_q  <= 1'b0;
            step_n_q     <= '1;
            dir_q        <= '1;
            playing_q    <= '0;
            note_q       <= '{default: '0};
            setp_q       <= '{default: '0};
            cnt_q        <= '{default: '0};
            track_q      <= '{default: '0};
        end else begin
            state_q      <= state_d;
            home_cnt_q   <= home_cnt_d;
            home_falls_q <= home_falls_d;
            cmd_ready_q  <= cmd_ready_d;
            step_n_q     <= step_n_d;
            dir_q        <= dir_d;
            playing_q    <= playing_d;
            note_q       <= note_d;
            setp_q       <= setp_d;
            cnt_q        <= cnt_d;
            track_q      <= track_d;
        end
    end

    assign cmd.cmd_ready = cmd_ready_q;
    assign step_n        = step_n_q;
    assign dir           = dir_q;
    assign playing       = playing_q;
endmodule
